// File: rtl/io_cond_pkg.sv
// Shared widths and defaults for the board switch/button input conditioner.
package io_cond_pkg;

   localparam int SW_W           = 32;
   localparam int BTN_W          = 4;
   localparam int IN_W           = SW_W + BTN_W;
   localparam int DEF_CLK_DIV    = 50000;
   localparam int DEF_STABLE_CNT = 4;

   // Counter width able to hold 0..max_val-1, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: two-flop synchronizer followed by a tick-qualified debouncer.
module debounce_bit
   import io_cond_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_rst_val,
   input  logic i_raw,
   output logic o_level
);

   localparam int              CW       = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CNT - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Any tick that agrees with the current level restarts qualification.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (i_tick) begin
         if (sync2_q == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= i_rst_val;
         sync2_q <= i_rst_val;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_level = level_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces board switches/buttons for the LSU, with press/release pulses.
module io_input_conditioner
   import io_cond_pkg::*;
#(
   parameter int CLK_DIV        = DEF_CLK_DIV,
   parameter int STABLE_CNT     = DEF_STABLE_CNT,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [SW_W-1:0]  i_sw_raw,
   input  logic [BTN_W-1:0] i_btn_raw,
   output logic [SW_W-1:0]  o_io_sw,
   output logic [BTN_W-1:0] o_io_btn,
   output logic [BTN_W-1:0] o_btn_press,
   output logic [BTN_W-1:0] o_btn_release,
   output logic             o_tick
);

   localparam int            DW       = cnt_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0]    div_q;
   logic [DW-1:0]    div_d;
   logic             tick;
   logic [IN_W-1:0]  raw_all;
   logic [IN_W-1:0]  rst_val_all;
   logic [IN_W-1:0]  level_all;
   logic [BTN_W-1:0] btn_q;

   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_q <= '0;
         btn_q <= '0;
      end else begin
         div_q <= div_d;
         btn_q <= level_all[IN_W-1:SW_W];
      end
   end

   // Buttons are normalised to 1 = pressed before they reach the synchronizers.
   assign raw_all     = {i_btn_raw ^ {BTN_W{BTN_ACTIVE_LOW}}, i_sw_raw};
   assign rst_val_all = {{BTN_W{BTN_ACTIVE_LOW}}, {SW_W{1'b0}}};

   for (genvar g = 0; g < IN_W; g++) begin : g_bit
      debounce_bit #(
         .STABLE_CNT (STABLE_CNT)
      ) u_db (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_tick    (tick),
         .i_rst_val (rst_val_all[g]),
         .i_raw     (raw_all[g]),
         .o_level   (level_all[g])
      );
   end

   assign o_io_sw       = level_all[SW_W-1:0];
   assign o_io_btn      = level_all[IN_W-1:SW_W];
   assign o_btn_press   = o_io_btn & ~btn_q;
   assign o_btn_release = ~o_io_btn & btn_q;
   assign o_tick        = tick;

endmodule
